// File: rtl/timer_log_pkg.sv
// timer_log_pkg: shared constants, types and width helpers for the timer event logger
package timer_log_pkg;
  localparam int DATA_W = 32;
  localparam logic [3:0] BE_ALL = 4'hF;
  localparam logic [7:0] OVF_MAX = 8'hFF;
  typedef logic [DATA_W-1:0] log_word_t;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int lvl_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous capture FIFO with flush, occupancy count and show-ahead head
module event_fifo
  import timer_log_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  log_word_t               din,
  output logic                    full,
  output logic                    empty,
  output logic [lvl_w(DEPTH)-1:0] level,
  output log_word_t               head
);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  log_word_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign head = mem[rd];
  // pointers and occupancy; flush discards everything and wins over push/pop
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
    end else begin
      rd <= rd + PW'(pop);
      wr <= wr + PW'(push);
      level <= level + LW'(push) - LW'(pop);
    end
  // storage is not reset: a slot is only presented after it has been written
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
endmodule

// File: rtl/timer_event_logger.sv
// timer_event_logger: captures timestamps on events and drains them into a circular RAM log
module timer_event_logger
  import timer_log_pkg::*;
#(
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 12'h800,
  parameter int                LOG_WORDS  = 1024,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear,
  input  logic                         event_in,
  input  logic [DATA_W-1:0]            timestamp,
  input  logic                         mem_grant,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [3:0]                   mem_byteenable,
  output logic                         mem_chipselect,
  output logic                         mem_write,
  output logic [DATA_W-1:0]            mem_writedata,
  output logic                         mem_clken,
  output logic [ptr_w(LOG_WORDS)-1:0]  wr_ptr,
  output logic                         wrapped,
  output logic [7:0]                   overflow_cnt,
  output logic [lvl_w(FIFO_DEPTH)-1:0] fifo_level
);
  logic full, empty, push, pop, drop;
  log_word_t head;
  assign pop = !empty && mem_grant && !clear;
  assign push = event_in && enable && !clear && (!full || pop);
  assign drop = event_in && enable && !clear && full && !pop;
  assign mem_write = pop;
  assign mem_chipselect = pop;
  assign mem_writedata = empty ? '0 : head;
  assign mem_address = BASE_ADDR + ADDR_W'(wr_ptr);
  assign mem_byteenable = BE_ALL;
  assign mem_clken = 1'b1;
  event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(clear),
    .din(timestamp),
    .full(full),
    .empty(empty),
    .level(fifo_level),
    .head(head)
  );
  // log write pointer, sticky wrap flag and saturating drop counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      wrapped <= 1'b0;
      overflow_cnt <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      wrapped <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + ptr_w(LOG_WORDS)'(pop);
      if (pop && wr_ptr == '1) wrapped <= 1'b1;
      if (drop && overflow_cnt != OVF_MAX) overflow_cnt <= overflow_cnt + 8'd1;
    end
endmodule

// File: tb/tb_timer_event_logger.sv
// tb_timer_event_logger: scoreboard bench, directed stimulus pushes expected RAM writes, monitor checks them
module tb_timer_event_logger;
  logic clk = 0, reset = 1, enable = 1, clear = 0, event_in = 0, mem_grant = 0;
  logic [31:0] timestamp = 0;
  logic [11:0] mem_address;
  logic [3:0] mem_byteenable;
  logic mem_chipselect, mem_write, mem_clken, wrapped;
  logic [31:0] mem_writedata;
  logic [9:0] wr_ptr;
  logic [7:0] overflow_cnt;
  logic [2:0] fifo_level;
  int compared = 0, mismatched = 0;
  logic [43:0] sb[$];
  logic [43:0] e;

  always #5 clk = ~clk;

  timer_event_logger dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .event_in(event_in),
    .timestamp(timestamp), .mem_grant(mem_grant), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .wr_ptr(wr_ptr), .wrapped(wrapped),
    .overflow_cnt(overflow_cnt), .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [31:0] ts);
    event_in = 1;
    timestamp = ts;
    tick(1);
    event_in = 0;
  endtask

  task automatic expect_wr(input logic [11:0] addr, input logic [31:0] data);
    sb.push_back({addr, data});
  endtask

  // monitor: every RAM write must match the oldest expected write
  always @(negedge clk)
    if (mem_write) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_address, mem_writedata);
      end else begin
        e = sb.pop_front();
        chk("write_addr", 32'(mem_address), 32'(e[43:32]));
        chk("write_data", mem_writedata, e[31:0]);
        chk("write_be", 32'(mem_byteenable), 32'hF);
        chk("write_cs", 32'(mem_chipselect), 32'd1);
      end
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_write", 32'(mem_write), 0);
    chk("rst_cs", 32'(mem_chipselect), 0);
    chk("rst_data", mem_writedata, 0);
    chk("rst_addr", 32'(mem_address), 32'h800);
    chk("rst_be", 32'(mem_byteenable), 32'hF);
    chk("rst_clken", 32'(mem_clken), 1);
    #19 reset = 0;
    tick(1);
    chk("init_ptr", 32'(wr_ptr), 0);
    chk("init_level", 32'(fifo_level), 0);
    chk("init_ovf", 32'(overflow_cnt), 0);
    chk("init_wrapped", 32'(wrapped), 0);
    // single event
    mem_grant = 1;
    expect_wr(12'h800, 32'h12345678);
    ev(32'h12345678);
    chk("single_no_bypass_level", 32'(fifo_level), 1);
    tick(1);
    chk("single_ptr", 32'(wr_ptr), 1);
    chk("single_level", 32'(fifo_level), 0);
    clear = 1;
    tick(1);
    clear = 0;
    chk("clear1_ptr", 32'(wr_ptr), 0);
    // overflow with grant held off
    mem_grant = 0;
    for (int i = 1; i <= 5; i++) ev(i);
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_cnt", 32'(overflow_cnt), 1);
    for (int i = 0; i < 4; i++) expect_wr(12'h800 + 12'(i), i + 1);
    mem_grant = 1;
    tick(4);
    chk("ovf_drain_level", 32'(fifo_level), 0);
    chk("ovf_drain_ptr", 32'(wr_ptr), 4);
    // full FIFO with simultaneous pop and push
    mem_grant = 0;
    for (int i = 0; i < 4; i++) begin
      expect_wr(12'h804 + 12'(i), 32'hA0 + i);
      ev(32'hA0 + i);
    end
    mem_grant = 1;
    expect_wr(12'h808, 32'hAA);
    ev(32'hAA);
    chk("fullpop_level", 32'(fifo_level), 4);
    chk("fullpop_ovf", 32'(overflow_cnt), 1);
    tick(4);
    chk("fullpop_drain_level", 32'(fifo_level), 0);
    chk("fullpop_ptr", 32'(wr_ptr), 9);
    // overflow counter saturation
    mem_grant = 0;
    for (int i = 0; i < 264; i++) ev(32'h100 + i);
    chk("sat_level", 32'(fifo_level), 4);
    chk("sat_ovf", 32'(overflow_cnt), 32'hFF);
    clear = 1;
    tick(1);
    clear = 0;
    chk("clear2_level", 32'(fifo_level), 0);
    chk("clear2_ovf", 32'(overflow_cnt), 0);
    chk("clear2_ptr", 32'(wr_ptr), 0);
    // wrap around the log region
    mem_grant = 1;
    for (int i = 1; i <= 1025; i++) begin
      expect_wr(12'h800 + 12'((i - 1) % 1024), i);
      ev(i);
      if (i == 1024) chk("prewrap_wrapped", 32'(wrapped), 0);
    end
    tick(1);
    chk("wrap_wrapped", 32'(wrapped), 1);
    chk("wrap_ptr", 32'(wr_ptr), 1);
    chk("wrap_level", 32'(fifo_level), 0);
    // clear colliding with an event, two entries pending
    mem_grant = 0;
    ev(32'hB0);
    ev(32'hB1);
    chk("clr_pending_level", 32'(fifo_level), 2);
    mem_grant = 1;
    clear = 1;
    event_in = 1;
    timestamp = 32'hB2;
    #4;
    chk("clr_no_write", 32'(mem_write), 0);
    tick(1);
    clear = 0;
    event_in = 0;
    chk("clr_level", 32'(fifo_level), 0);
    chk("clr_ptr", 32'(wr_ptr), 0);
    chk("clr_wrapped", 32'(wrapped), 0);
    chk("clr_ovf", 32'(overflow_cnt), 0);
    tick(3);
    // capture disabled
    enable = 0;
    ev(32'hC0);
    chk("disabled_level", 32'(fifo_level), 0);
    tick(2);
    enable = 1;
    // reset in the middle of a drain
    mem_grant = 0;
    for (int i = 0; i < 5; i++) ev(32'hD0 + i);
    chk("prerst_level", 32'(fifo_level), 4);
    chk("prerst_ovf", 32'(overflow_cnt), 1);
    mem_grant = 1;
    #1;
    chk("prerst_write", 32'(mem_write), 1);
    reset = 1;
    #1;
    chk("midrst_write", 32'(mem_write), 0);
    chk("midrst_cs", 32'(mem_chipselect), 0);
    chk("midrst_level", 32'(fifo_level), 0);
    chk("midrst_ovf", 32'(overflow_cnt), 0);
    chk("midrst_data", mem_writedata, 0);
    @(negedge clk);
    reset = 0;
    tick(1);
    chk("postrst_ptr", 32'(wr_ptr), 0);
    chk("postrst_addr", 32'(mem_address), 32'h800);
    chk("postrst_be", 32'(mem_byteenable), 32'hF);
    chk("postrst_level", 32'(fifo_level), 0);
    tick(2);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/timer_event_logger.md
Name: timer_event_logger

Overview:
- Upstream Avalon-MM write master that feeds the 32-bit single-port on-chip RAM (4096 words, byte-enabled, 1-cycle read latency, no waitrequest).
- Captures the free-running timer value on each event pulse into a small FIFO.
- Drains the FIFO into a circular log region of the RAM, one word per granted cycle.
- Software reads the log through the RAM's other access path and reads or clears status here.

Parameters:
ADDR_W, 12, word address width of the RAM
BASE_ADDR, 12'h800, first word of the log region
LOG_WORDS, 1024, log length in words; power of two; BASE_ADDR+LOG_WORDS <= 2**ADDR_W
FIFO_DEPTH, 4, capture FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
enable  in  1  capture enable; does not gate draining
clear  in  1  synchronous clear of log state (1-cycle pulse)
event_in  in  1  capture strobe; every high cycle is one event
timestamp  in  32  timer counter value, sampled when event_in=1
mem_grant  in  1  RAM port available to this master this cycle
mem_address  out  ADDR_W  RAM word address
mem_byteenable  out  4  byte enables
mem_chipselect  out  1  RAM select
mem_write  out  1  RAM write strobe
mem_writedata  out  32  RAM write data
mem_clken  out  1  RAM clock enable
wr_ptr  out  log2(LOG_WORDS)  offset of the next log word to write
wrapped  out  1  sticky: log has wrapped at least once
overflow_cnt  out  8  events dropped because the FIFO was full; saturates at 255
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert upstream) clears:
  - FIFO, wr_ptr, wrapped and overflow_cnt to 0.
  - mem_chipselect, mem_write and mem_writedata to 0; mem_address to BASE_ADDR.
  - mem_byteenable and mem_clken are constant 4'hF and 1, including during reset.
- Push: event_in=1 and enable=1 and clear=0 at a rising edge writes timestamp into the FIFO tail.
- Drain (combinational from registered state and mem_grant):
  - mem_chipselect = mem_write = (fifo_level != 0) & mem_grant & ~clear.
  - mem_writedata = FIFO head.
  - mem_address = BASE_ADDR + wr_ptr.
  - A write cycle pops the head and increments wr_ptr at the same edge; the write completes in that cycle.
- Latency: an event at edge N is written no earlier than the cycle after edge N; back-to-back writes run one per cycle while granted.
- Full FIFO, event, no pop that cycle: event dropped and overflow_cnt += 1 (held at 255).
- Full FIFO, event, pop the same cycle: push accepted; occupancy is unchanged.
- Empty FIFO plus event: no same-cycle bypass; the event is stored and written next cycle.
- mem_grant=0: no write; FIFO contents held; wr_ptr held.
- Wrap: wr_ptr goes from LOG_WORDS-1 to 0 and wrapped is set to 1 (sticky until clear or reset); the next address is BASE_ADDR.
- clear=1:
  - Has priority over push and pop that cycle: no write strobe, incoming event discarded.
  - Next edge zeroes FIFO, wr_ptr, wrapped and overflow_cnt.
- enable=0: no capture; draining continues until the FIFO is empty.
- Reset asserted mid-drain: the write strobe drops immediately (async); pending entries are lost.

Decomposition:
- Package timer_log_pkg:
  - Constants DATA_W=32, BE_ALL=4'hF, OVF_MAX=8'hFF.
  - Typedef log_word_t (32-bit).
  - Function clog2-based width helpers.
- Sub-module event_fifo:
  - Synchronous FIFO, width DATA_W, depth FIFO_DEPTH.
  - Signals: push, pop, flush, full, empty, level, head.
  - Same async reset.
- Top holds the address counter, wrapped and overflow logic, and the Avalon drive.

Test Plan:
- Reset: assert reset mid-cycle with the FIFO non-empty -> mem_write/mem_chipselect go 0 immediately; after release, wr_ptr=0, fifo_level=0, overflow_cnt=0, mem_address=12'h800, mem_byteenable=4'hF.
- Single event: grant=1, event_in at edge N with timestamp=32'h12345678 -> next cycle one write to 12'h800 with data 32'h12345678 and be 4'hF; wr_ptr=1.
- Overflow: grant=0, five consecutive events with timestamps 1..5 -> fifo_level=4, overflow_cnt=1; then grant=1 -> four writes on consecutive cycles to 12'h800..12'h803 with data 1,2,3,4.
- Full plus simultaneous pop: FIFO full, grant=1, event with timestamp 32'hAA -> write issued, push accepted, overflow_cnt unchanged, 32'hAA written last.
- Wrap: 1025 events with grant=1 -> event 1025 written to 12'h800; wrapped=1, wr_ptr=1.
- Clear: clear and event_in in the same cycle with 2 entries pending -> no write that cycle; next cycle fifo_level=0, wr_ptr=0, wrapped=0, overflow_cnt=0, and no further writes.
